// File: rtl/ifetch_queue.sv
// -----------------------------------------------------------------------------
// ifetch_queue
//
// Instruction-fetch queue sitting between the program counter and decode.
// Every cycle it either issues a fetch at the current PC, holds the PC when
// the queue has no credit left, or loads a redirect target and flushes all
// fetched work. Fetched {pc, instruction} pairs are buffered in a small FIFO
// and handed to decode through a valid/ready handshake.
//
// Ports
//   clk              rising-edge clock
//   clr              asynchronous, active-high reset
//   pc_out           current PC value (from the PC register)
//   pc_in            value the PC loads when pc_ctrl = 1
//   pc_ctrl          1: PC loads pc_in, 0: PC increments by 4
//   imem_en          read strobe to instruction memory
//   imem_addr        read address, always equal to pc_out
//   imem_rdata       read data, valid one cycle after imem_en
//   redirect         flush the queue and restart fetch at redirect_target
//   redirect_target  new fetch address (bits [1:0] ignored)
//   inst_valid       FIFO head is valid
//   inst_ready       decode accepts the head this cycle
//   inst_data        head instruction
//   inst_pc          head PC
//   count            current FIFO occupancy
// -----------------------------------------------------------------------------
module ifetch_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          clr,
   input  logic [31:0]   pc_out,
   output logic [31:0]   pc_in,
   output logic          pc_ctrl,
   output logic          imem_en,
   output logic [31:0]   imem_addr,
   input  logic [31:0]   imem_rdata,
   input  logic          redirect,
   input  logic [31:0]   redirect_target,
   output logic          inst_valid,
   input  logic          inst_ready,
   output logic [31:0]   inst_data,
   output logic [31:0]   inst_pc,
   output logic [CW-1:0] count
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   // Per-cycle fetch mode, in priority order.
   localparam logic [1:0] MODE_REDIRECT = 2'd0;
   localparam logic [1:0] MODE_ISSUE    = 2'd1;
   localparam logic [1:0] MODE_HOLD     = 2'd2;

   logic [63:0]   fifo_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          req_v_q,  req_v_d;
   logic [31:0]   req_pc_q, req_pc_d;

   logic [CW:0]   credit_used;
   logic          issue;
   logic          do_write;
   logic          do_pop;
   logic [1:0]    mode;

   // Credit counts stored entries plus the read still in flight. A pop in
   // the same cycle is deliberately not credited back, keeping the check
   // off the decode-ready path.
   assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, req_v_q};
   assign issue       = !redirect && (credit_used < DEPTH_C);

   always_comb begin
      if (redirect)   mode = MODE_REDIRECT;
      else if (issue) mode = MODE_ISSUE;
      else            mode = MODE_HOLD;
   end

   // PC control and memory strobe.
   // NOTE: every output gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      pc_ctrl = 1'b1;
      pc_in   = pc_out;
      imem_en = 1'b0;
      case (mode)
         MODE_REDIRECT: pc_in = {redirect_target[31:2], 2'b00};
         MODE_ISSUE: begin
            pc_ctrl = 1'b0;
            imem_en = 1'b1;
         end
         default: ;
      endcase
   end

   assign imem_addr  = pc_out;
   assign inst_valid = |count_q;
   assign count      = count_q;
   assign {inst_pc, inst_data} = fifo_q[rd_ptr_q];

   // A redirect cancels both the capture of the in-flight read and any pop.
   assign do_write = req_v_q && !redirect;
   assign do_pop   = inst_valid && inst_ready && !redirect;

   always_comb begin
      req_v_d  = (mode == MODE_ISSUE);
      req_pc_d = issue ? pc_out : req_pc_q;
      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         rd_ptr_d = rd_ptr_q + AW'(do_pop);
         wr_ptr_d = wr_ptr_q + AW'(do_write);
         count_d  = count_q + CW'(do_write) - CW'(do_pop);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         req_v_q  <= 1'b0;
         req_pc_q <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         req_v_q  <= req_v_d;
         req_pc_q <= req_pc_d;
      end
   end

   // NOTE: storage is left out of reset; count gates visibility, so stale
   // contents are never presented as valid and the array stays plain RAM.
   always_ff @(posedge clk) begin
      if (do_write) fifo_q[wr_ptr_q] <= {req_pc_q, imem_rdata};
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// -----------------------------------------------------------------------------
// tb_ifetch_queue
//
// Bench for ifetch_queue. Models the external PC register and a one-cycle
// instruction memory (instr = addr ^ 0xA5A50000). The delivered stream is
// checked against its architectural definition: after reset or a redirect,
// decode must see consecutive word addresses starting at 0 or the aligned
// target, each with matching data, with no gaps or duplicates.
// -----------------------------------------------------------------------------
module tb_ifetch_queue;

   localparam int          DEPTH = 4;
   localparam int          CW    = $clog2(DEPTH) + 1;
   localparam logic [31:0] KEY   = 32'hA5A5_0000;

   logic          clk = 1'b0;
   logic          clr;
   logic [31:0]   pc_q;
   logic [31:0]   pc_in;
   logic          pc_ctrl;
   logic          imem_en;
   logic [31:0]   imem_addr;
   logic [31:0]   imem_rdata;
   logic          redirect;
   logic [31:0]   redirect_target;
   logic          inst_valid;
   logic          inst_ready;
   logic [31:0]   inst_data;
   logic [31:0]   inst_pc;
   logic [CW-1:0] count;

   int            n_chk  = 0;
   int            n_pass = 0;
   logic [31:0]   exp_pc;

   ifetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk             (clk),
      .clr             (clr),
      .pc_out          (pc_q),
      .pc_in           (pc_in),
      .pc_ctrl         (pc_ctrl),
      .imem_en         (imem_en),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst_data       (inst_data),
      .inst_pc         (inst_pc),
      .count           (count)
   );

   always #5 clk = ~clk;

   // External PC register.
   always @(posedge clk or posedge clr) begin
      if (clr) pc_q <= 32'h0;
      else     pc_q <= pc_ctrl ? pc_in : pc_q + 32'd4;
   end

   // Synchronous instruction memory; junk on cycles without a read strobe.
   always @(posedge clk) begin
      imem_rdata <= imem_en ? (imem_addr ^ KEY) : $urandom;
   end

   // Apply inputs just after a rising edge, return at the following falling
   // edge where outputs for that cycle are stable.
   task automatic set_in(input logic rdy, input logic redir, input logic [31:0] tgt);
      @(posedge clk); #1;
      inst_ready      = rdy;
      redirect        = redir;
      redirect_target = tgt;
      @(negedge clk);
   endtask

   // Pulse clr for one cycle; returns just after release (cycle 0).
   task automatic do_reset(input logic rdy);
      @(posedge clk); #1;
      clr = 1'b1; redirect = 1'b0; redirect_target = 32'h0; inst_ready = rdy;
      @(posedge clk); #1;
      clr = 1'b0;
      exp_pc = 32'h0;
   endtask

   task automatic test_reset;
      clr = 1'b1; redirect = 1'b0; redirect_target = 32'h0; inst_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({inst_valid, count, pc_ctrl, imem_en} !== {1'b0, CW'(0), 1'b0, 1'b1})
         $display("FAIL reset_outputs: valid/count/pc_ctrl/imem_en = %b/%0d/%b/%b, expected 0/0/0/1",
                  inst_valid, count, pc_ctrl, imem_en);
      else n_pass++;
      @(posedge clk); #1;
      clr = 1'b0; inst_ready = 1'b1; exp_pc = 32'h0;
      @(negedge clk);
      n_chk++;
      if ({inst_valid, imem_en, imem_addr} !== {1'b0, 1'b1, 32'h0})
         $display("FAIL startup_c0: valid=%b imem_en=%b addr=%h, expected 0/1/00000000",
                  inst_valid, imem_en, imem_addr);
      else n_pass++;
      for (int i = 1; i <= 12; i++) begin
         set_in(1'b1, 1'b0, 32'h0);
         n_chk++;
         if (inst_valid !== (i >= 2))
            $display("FAIL startup_valid c%0d: valid=%b, expected %b", i, inst_valid, i >= 2);
         else n_pass++;
         if (inst_valid && inst_ready && !redirect) begin
            n_chk++;
            if (inst_pc !== exp_pc || inst_data !== (exp_pc ^ KEY))
               $display("FAIL startup_stream: pc=%h data=%h, expected pc=%h data=%h",
                        inst_pc, inst_data, exp_pc, exp_pc ^ KEY);
            else n_pass++;
            exp_pc += 32'd4;
         end
      end
   endtask

   task automatic test_backpressure;
      do_reset(1'b0);
      for (int i = 1; i <= 8; i++) begin
         set_in(1'b0, 1'b0, 32'h0);
         n_chk++;
         if (count > CW'(DEPTH))
            $display("FAIL bp_count_bound c%0d: count=%0d, expected <= %0d", i, count, DEPTH);
         else n_pass++;
      end
      n_chk++;
      if ({count, pc_ctrl, imem_en, pc_in, pc_q} !== {CW'(DEPTH), 1'b1, 1'b0, 32'h10, 32'h10})
         $display("FAIL bp_hold: count=%0d pc_ctrl=%b imem_en=%b pc_in=%h pc_out=%h, expected 4/1/0/10/10",
                  count, pc_ctrl, imem_en, pc_in, pc_q);
      else n_pass++;
      n_chk++;
      if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h0, KEY})
         $display("FAIL bp_head_stable: valid=%b pc=%h data=%h, expected 1/00000000/%h",
                  inst_valid, inst_pc, inst_data, KEY);
      else n_pass++;
      for (int i = 0; i < 10; i++) begin
         set_in(1'b1, 1'b0, 32'h0);
         n_chk++;
         if (inst_valid !== 1'b1)
            $display("FAIL bp_drain_gap d%0d: valid=%b, expected 1", i, inst_valid);
         else n_pass++;
         if (inst_valid && inst_ready && !redirect) begin
            n_chk++;
            if (inst_pc !== exp_pc || inst_data !== (exp_pc ^ KEY))
               $display("FAIL bp_drain_stream: pc=%h data=%h, expected pc=%h data=%h",
                        inst_pc, inst_data, exp_pc, exp_pc ^ KEY);
            else n_pass++;
            exp_pc += 32'd4;
         end
      end
   endtask

   task automatic test_redirect_mid;
      do_reset(1'b0);
      set_in(1'b0, 1'b0, 32'h0);
      set_in(1'b0, 1'b0, 32'h0);
      set_in(1'b0, 1'b1, 32'h100);
      n_chk++;
      if ({count, pc_ctrl, imem_en, pc_in} !== {CW'(2), 1'b1, 1'b0, 32'h100})
         $display("FAIL redir_mid_cycle: count=%0d pc_ctrl=%b imem_en=%b pc_in=%h, expected 2/1/0/00000100",
                  count, pc_ctrl, imem_en, pc_in);
      else n_pass++;
      exp_pc = 32'h100;
      for (int i = 1; i <= 6; i++) begin
         set_in(1'b1, 1'b0, 32'h0);
         if (i == 1) begin
            n_chk++;
            if ({inst_valid, count, imem_en, imem_addr} !== {1'b0, CW'(0), 1'b1, 32'h100})
               $display("FAIL redir_mid_flush: valid=%b count=%0d imem_en=%b addr=%h, expected 0/0/1/00000100",
                        inst_valid, count, imem_en, imem_addr);
            else n_pass++;
         end
         n_chk++;
         if (inst_valid !== (i >= 3))
            $display("FAIL redir_mid_latency r+%0d: valid=%b, expected %b", i, inst_valid, i >= 3);
         else n_pass++;
         if (inst_valid && inst_ready && !redirect) begin
            n_chk++;
            if (inst_pc !== exp_pc || inst_data !== (exp_pc ^ KEY))
               $display("FAIL redir_mid_stream: pc=%h data=%h, expected pc=%h data=%h",
                        inst_pc, inst_data, exp_pc, exp_pc ^ KEY);
            else n_pass++;
            exp_pc += 32'd4;
         end
      end
   endtask

   task automatic test_redirect_pop_write;
      logic [31:0] t1, t2;
      do_reset(1'b1);
      for (int i = 1; i <= 4; i++) begin
         set_in(1'b1, 1'b0, 32'h0);
         if (inst_valid && inst_ready && !redirect) begin
            n_chk++;
            if (inst_pc !== exp_pc || inst_data !== (exp_pc ^ KEY))
               $display("FAIL rpw_pre_stream: pc=%h data=%h, expected pc=%h data=%h",
                        inst_pc, inst_data, exp_pc, exp_pc ^ KEY);
            else n_pass++;
            exp_pc += 32'd4;
         end
      end
      set_in(1'b1, 1'b1, 32'h300);
      n_chk++;
      if (inst_valid !== 1'b1)
         $display("FAIL rpw_setup: valid=%b, expected 1 (pop offered during redirect)", inst_valid);
      else n_pass++;
      set_in(1'b1, 1'b0, 32'h0);
      n_chk++;
      if ({count, inst_valid} !== {CW'(0), 1'b0})
         $display("FAIL rpw_flush: count=%0d valid=%b, expected 0/0", count, inst_valid);
      else n_pass++;
      // Back-to-back redirects: only the last target survives.
      t1 = $urandom;
      t2 = $urandom;
      set_in(1'b1, 1'b1, t1);
      set_in(1'b1, 1'b1, t2);
      exp_pc = {t2[31:2], 2'b00};
      for (int i = 1; i <= 6; i++) begin
         set_in(1'b1, 1'b0, 32'h0);
         n_chk++;
         if (inst_valid !== (i >= 3))
            $display("FAIL rpw_b2b_latency r+%0d: valid=%b, expected %b", i, inst_valid, i >= 3);
         else n_pass++;
         if (inst_valid && inst_ready && !redirect) begin
            n_chk++;
            if (inst_pc !== exp_pc || inst_data !== (exp_pc ^ KEY))
               $display("FAIL rpw_b2b_stream: pc=%h data=%h, expected pc=%h data=%h",
                        inst_pc, inst_data, exp_pc, exp_pc ^ KEY);
            else n_pass++;
            exp_pc += 32'd4;
         end
      end
   endtask

   task automatic test_misaligned;
      do_reset(1'b1);
      set_in(1'b1, 1'b0, 32'h0);
      set_in(1'b1, 1'b1, 32'h203);
      n_chk++;
      if ({pc_ctrl, imem_en, pc_in} !== {1'b1, 1'b0, 32'h200})
         $display("FAIL misaligned_pc_in: pc_ctrl=%b imem_en=%b pc_in=%h, expected 1/0/00000200",
                  pc_ctrl, imem_en, pc_in);
      else n_pass++;
      exp_pc = 32'h200;
      for (int i = 1; i <= 5; i++) begin
         set_in(1'b1, 1'b0, 32'h0);
         if (i == 1) begin
            n_chk++;
            if (imem_addr !== 32'h200)
               $display("FAIL misaligned_fetch: addr=%h, expected 00000200", imem_addr);
            else n_pass++;
         end
         if (inst_valid && inst_ready && !redirect) begin
            n_chk++;
            if (inst_pc !== exp_pc || inst_data !== (exp_pc ^ KEY))
               $display("FAIL misaligned_stream: pc=%h data=%h, expected pc=%h data=%h",
                        inst_pc, inst_data, exp_pc, exp_pc ^ KEY);
            else n_pass++;
            exp_pc += 32'd4;
         end
      end
   endtask

   task automatic test_async_reset;
      do_reset(1'b0);
      repeat (4) set_in(1'b0, 1'b0, 32'h0);
      n_chk++;
      if (count !== CW'(3))
         $display("FAIL async_setup: count=%0d, expected 3", count);
      else n_pass++;
      #2 clr = 1'b1;
      #1;
      n_chk++;
      if ({inst_valid, count} !== {1'b0, CW'(0)})
         $display("FAIL async_clear: valid=%b count=%0d, expected 0/0 without a clock", inst_valid, count);
      else n_pass++;
      @(posedge clk); #1;
      clr = 1'b0; inst_ready = 1'b1; exp_pc = 32'h0;
      @(negedge clk);
      for (int i = 1; i <= 6; i++) begin
         set_in(1'b1, 1'b0, 32'h0);
         n_chk++;
         if (inst_valid !== (i >= 2))
            $display("FAIL async_restart_valid c%0d: valid=%b, expected %b", i, inst_valid, i >= 2);
         else n_pass++;
         if (inst_valid && inst_ready && !redirect) begin
            n_chk++;
            if (inst_pc !== exp_pc || inst_data !== (exp_pc ^ KEY))
               $display("FAIL async_restart_stream: pc=%h data=%h, expected pc=%h data=%h",
                        inst_pc, inst_data, exp_pc, exp_pc ^ KEY);
            else n_pass++;
            exp_pc += 32'd4;
         end
      end
   endtask

   // Random ready/redirect traffic. Occupancy is tracked as entries landed
   // minus entries consumed; a fetch is allowed only while stored plus
   // outstanding reads stay below DEPTH.
   task automatic test_random;
      int          occ;
      int          inflight;
      logic        rdy, redir, exp_issue, popped;
      logic [31:0] tgt;
      do_reset(1'b0);
      occ      = 0;
      inflight = 1;   // cycle 0 after reset fetched address 0
      for (int n = 0; n < 400; n++) begin
         rdy   = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 11) == 0);
         tgt   = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 255);
         set_in(rdy, redir, tgt);
         exp_issue = !redir && ((occ + inflight) < DEPTH);
         n_chk++;
         if ({count, inst_valid} !== {CW'(occ), occ != 0})
            $display("FAIL rnd_occupancy n=%0d: count=%0d valid=%b, expected %0d/%b",
                     n, count, inst_valid, occ, occ != 0);
         else n_pass++;
         n_chk++;
         if (imem_addr !== pc_q || imem_en !== exp_issue || pc_ctrl !== !exp_issue)
            $display("FAIL rnd_fetch n=%0d: addr=%h pc=%h imem_en=%b pc_ctrl=%b, expected imem_en=%b",
                     n, imem_addr, pc_q, imem_en, pc_ctrl, exp_issue);
         else n_pass++;
         if (!exp_issue) begin
            n_chk++;
            if (pc_in !== (redir ? {tgt[31:2], 2'b00} : pc_q))
               $display("FAIL rnd_pc_in n=%0d: pc_in=%h, expected %h",
                        n, pc_in, redir ? {tgt[31:2], 2'b00} : pc_q);
            else n_pass++;
         end
         popped = (occ != 0) && rdy && !redir;
         if (inst_valid && inst_ready && !redirect) begin
            n_chk++;
            if (inst_pc !== exp_pc || inst_data !== (exp_pc ^ KEY))
               $display("FAIL rnd_stream n=%0d: pc=%h data=%h, expected pc=%h data=%h",
                        n, inst_pc, inst_data, exp_pc, exp_pc ^ KEY);
            else n_pass++;
            exp_pc += 32'd4;
         end
         if (redir) begin
            exp_pc = {tgt[31:2], 2'b00};
            occ    = 0;
         end else begin
            occ = occ + inflight - int'(popped);
         end
         inflight = int'(exp_issue);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_backpressure();
      test_redirect_mid();
      test_redirect_pop_write();
      test_misaligned();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction-fetch queue on the output side of the program counter. Each cycle it takes the PC value, reads the instruction memory, and buffers fetched instruction/PC pairs in a FIFO toward decode with a valid/ready handshake. It also closes the loop back into the PC by driving the PC's load control and load value. It holds the PC when the queue is out of credit, and loads a redirect target on a taken branch or jump, flushing all fetched work.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2; full throughput requires ≥3
- CW, $clog2(DEPTH)+1, width of the `count` output
- clk  in  1  clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- pc_out  in  32  current PC value
- pc_in  out  32  value the PC loads when `pc_ctrl`=1
- pc_ctrl  out  1  1: PC loads `pc_in`; 0: PC increments by 4
- imem_en  out  1  read strobe to instruction memory
- imem_addr  out  32  read address; always equals `pc_out`
- imem_rdata  in  32  read data, valid exactly 1 cycle after `imem_en`
- redirect  in  1  flush and restart fetch at `redirect_target`
- redirect_target  in  32  new fetch address
- inst_valid  out  1  FIFO head is valid
- inst_ready  in  1  decode accepts the head this cycle
- inst_data  out  32  head instruction
- inst_pc  out  32  head PC
- count  out  CW  current FIFO occupancy

## Operation
- **Registered state**
  - FIFO storage: DEPTH × 64 bits ({pc, instr}).
  - Pointers `rd_ptr` and `wr_ptr`, each log2(DEPTH) bits. They wrap modulo DEPTH.
  - `count`.
  - In-flight register: `req_v` and `req_pc[31:0]`.
- **Issue rule** (combinational): `issue = !redirect && (count + req_v) < DEPTH`. The credit check deliberately ignores a same-cycle pop (conservative).
- **Mode per cycle**, in priority order:
  - REDIRECT (`redirect`=1): `pc_ctrl`=1, `pc_in` = {redirect_target[31:2], 2'b00}, `imem_en`=0.
  - ISSUE (`issue`=1): `pc_ctrl`=0, `imem_en`=1. On the clock edge, `req_v`←1 and `req_pc`←`pc_out`.
  - HOLD (otherwise): `pc_ctrl`=1, `pc_in`=`pc_out`, `imem_en`=0. On the clock edge, `req_v`←0.
  - In REDIRECT, `req_v`←0 on the clock edge.
- **Capture**
  - A cycle with `req_v`=1 and `redirect`=0 writes {`req_pc`, `imem_rdata`} at `wr_ptr`, then `wr_ptr`++.
  - A cycle with `req_v`=1 and `redirect`=1 discards the in-flight read. No write occurs.
- **Pop**
  - `inst_valid` = (`count`≠0).
  - `inst_data` and `inst_pc` come from the entry at `rd_ptr` and are stable while `inst_valid`=1 and `inst_ready`=0.
  - A pop occurs when `inst_valid` && `inst_ready` && !`redirect`; then `rd_ptr`++.
- **Count update**: `count` += write − pop. Simultaneous write and pop leaves `count` unchanged. Overflow is impossible by construction of the credit rule.
- **Flush** (`redirect`=1):
  - `rd_ptr`, `wr_ptr`, `count` ← 0 at the clock edge.
  - Any same-cycle pop or write is cancelled.
  - `inst_valid` is 0 from the next cycle.
- **Reset** (`clr`=1, async):
  - `rd_ptr`, `wr_ptr`, `count`, `req_v`, `req_pc` ← 0.
  - `inst_valid`=0. `count`=0. FIFO storage is not reset.
  - Combinational outputs follow their rules: with `count`=0 and `redirect`=0, mode is ISSUE, so `pc_ctrl`=0 and `imem_en`=1 during reset. The PC's own reset dominates.
- **Redirect target**: bits [1:0] are forced to 0. No other checking is performed.

## Timing
- Issue at cycle n (address A) → `imem_rdata` for A at n+1 → entry written at the n+1 edge → `inst_valid`=1 with `inst_pc`=A at n+2.
- With DEPTH≥3 and `inst_ready` held at 1, one instruction is delivered per cycle after 2-cycle startup latency. DEPTH=2 alternates ISSUE/HOLD.
- PC sequence: after an ISSUE at A, `pc_out`=A+4 next cycle. A HOLD keeps `pc_out` unchanged. A REDIRECT to T gives `pc_out`=T next cycle, and T is issued that cycle if credit allows.
- Redirect to first new `inst_valid`: 2 cycles after the cycle in which the target is issued.
- Back-to-back redirects: each one flushes. Only the last target survives.
- Backpressure: with `inst_ready`=0, the FIFO fills to DEPTH and then stays in HOLD. `count` never exceeds DEPTH.

## Test plan
- **Reset and startup**: `clr` pulse, then `inst_ready`=1 and memory returns `instr = addr ^ 0xA5A50000`. Required response: `inst_valid` rises 2 cycles after `clr` falls, and `inst_pc` = 0x0, 0x4, 0x8, … on consecutive cycles with matching data.
- **Backpressure**: `inst_ready`=0 from startup with DEPTH=4. Required response: `count` reaches 4, `pc_ctrl`=1, `pc_in`=`pc_out`=0x10, and `imem_en`=0. Then set `inst_ready`=1. Required response: 0x0 through 0xC drain in order, followed by 0x10 with no gap and no duplicate.
- **Redirect mid-stream**: assert `redirect` for one cycle with target 0x100 while `count`=2 and `req_v`=1. Required response: `inst_valid`=0 the next cycle, `count`=0, the in-flight word is dropped, and the next delivered `inst_pc`=0x100, then 0x104.
- **Redirect with simultaneous pop and write**: `redirect`=1 with `inst_ready`=1 and `req_v`=1. Required response: no pop is counted, no write occurs, and `count`=0 after the edge.
- **Misaligned target**: `redirect_target`=0x203. Required response: `pc_in`=0x200, and the first delivered `inst_pc`=0x200.
- **Asynchronous reset mid-operation**: `clr` asserted between clock edges while `count`=3. Required response: `inst_valid` and `count` go to 0 immediately without a clock, and fetch restarts at 0x0 after `clr` is released.
